sdram_write_fifo: RTL and testbench

Synchronous write buffer that sits directly upstream of the SDRAM write sequencer. It accepts 32-bit host writes with byte selects and address, and stores them as 36-bit entries. It presents the entries on the sequencer's pull-style FIFO port, together with the SDRAM address of the head entry. It only admits address-contiguous runs, so the sequencer can latch the address once and then self-increment while draining.

---
 rtl/sdram_write_fifo_pkg.sv | 8 +
 rtl/sdram_fifo_mem.sv | 24 ++
 rtl/sdram_write_fifo.sv | 58 +++++
 tb/tb_sdram_write_fifo.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/sdram_write_fifo_pkg.sv
// sdram_write_fifo_pkg: shared widths and types for the SDRAM write buffer
package sdram_write_fifo_pkg;
  localparam int SDRAM_FIFO_WIDTH = 36;
  localparam int SDRAM_ADDR_WIDTH = 22;
  localparam int SDRAM_ADDR_STEP = 2;
  typedef logic [SDRAM_ADDR_WIDTH-1:0] addr_t;
  typedef logic [SDRAM_FIFO_WIDTH-1:0] entry_t;
endpackage

// File: rtl/sdram_fifo_mem.sv
// sdram_fifo_mem: simple dual-port RAM with registered read-enable output
module sdram_fifo_mem
  import sdram_write_fifo_pkg::*;
#(
  parameter int DEPTH_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [DEPTH_BITS-1:0] waddr,
  input  entry_t                wdata,
  input  logic                  re,
  input  logic [DEPTH_BITS-1:0] raddr,
  output entry_t                rdata
);
  entry_t mem [2**DEPTH_BITS];
  // write port, no reset so the array maps onto block RAM
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // registered read; output register clears on reset and holds between pops
  always_ff @(posedge clk)
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/sdram_write_fifo.sv
// sdram_write_fifo: contiguous-run write buffer feeding the SDRAM write sequencer
module sdram_write_fifo
  import sdram_write_fifo_pkg::*;
#(
  parameter int DEPTH_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_stb,
  input  logic [21:0]           in_address,
  input  logic [31:0]           in_data,
  input  logic [3:0]            in_sel,
  output logic                  in_ready,
  output logic [21:0]           app_address,
  output logic [35:0]           fifo_data,
  input  logic                  fifo_read,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic [DEPTH_BITS:0]   fifo_count
);
  localparam logic [DEPTH_BITS:0] full_count = 1 << DEPTH_BITS;
  logic [DEPTH_BITS:0] wr_ptr, rd_ptr, count;
  addr_t head_address, next_address;
  logic wr, rd;
  assign fifo_count = count;
  assign fifo_empty = count == '0;
  assign fifo_full = count == full_count;
  assign app_address = head_address;
  assign in_ready = ~fifo_full & (fifo_empty | in_address == next_address);
  assign wr = in_stb & in_ready;
  assign rd = fifo_read & ~fifo_empty;
  sdram_fifo_mem #(.DEPTH_BITS(DEPTH_BITS)) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr),
    .waddr (wr_ptr[DEPTH_BITS-1:0]),
    .wdata ({~in_sel, in_data}),
    .re    (rd),
    .raddr (rd_ptr[DEPTH_BITS-1:0]),
    .rdata (fifo_data)
  );
  // pointers, occupancy and the run's head/next addresses
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      head_address <= '0;
      next_address <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (wr) next_address <= in_address + addr_t'(SDRAM_ADDR_STEP);
      if (wr & fifo_empty) head_address <= in_address;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      if (rd) head_address <= head_address + addr_t'(SDRAM_ADDR_STEP);
      if (wr != rd) count <= wr ? count + 1'b1 : count - 1'b1;
    end
endmodule

// File: tb/tb_sdram_write_fifo.sv
// tb_sdram_write_fifo: table vectors plus scoreboarded sequences for sdram_write_fifo
module tb_sdram_write_fifo;
  logic clk = 0, rst = 1;
  logic in_stb = 0, fifo_read = 0;
  logic [21:0] in_address = '0;
  logic [31:0] in_data = '0;
  logic [3:0] in_sel = '0;
  logic in_ready, fifo_empty, fifo_full;
  logic [21:0] app_address;
  logic [35:0] fifo_data;
  logic [4:0] fifo_count;
  int errors = 0, checks = 0;
  typedef struct {
    logic [21:0] addr;
    logic [35:0] data;
  } ent_t;
  ent_t q[$];
  logic [21:0] model_next = '0;
  logic [35:0] last_data = '0;
  typedef struct {
    logic stb;
    logic [21:0] addr;
    logic [31:0] data;
    logic [3:0] sel;
    logic rd;
    logic exp_ready;
    logic exp_empty;
    logic [4:0] exp_count;
    logic [21:0] exp_app;
    logic [35:0] exp_data;
  } vec_t;
  vec_t vecs[4];
  sdram_write_fifo #(.DEPTH_BITS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_stb      (in_stb),
    .in_address  (in_address),
    .in_data     (in_data),
    .in_sel      (in_sel),
    .in_ready    (in_ready),
    .app_address (app_address),
    .fifo_data   (fifo_data),
    .fifo_read   (fifo_read),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .fifo_count  (fifo_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic do_reset();
    rst = 1;
    in_stb = 0;
    fifo_read = 0;
    @(posedge clk);
    #1;
    rst = 0;
    q.delete();
    model_next = '0;
    last_data = '0;
  endtask
  task automatic cyc(input logic stb, input logic [21:0] a, input logic rd, output logic acc);
    logic [31:0] d;
    logic [3:0] s;
    logic exp_rdy, pop;
    ent_t e;
    d = $urandom;
    s = 4'($urandom);
    in_stb = stb;
    in_address = a;
    in_data = d;
    in_sel = s;
    fifo_read = rd;
    #1;
    exp_rdy = q.size() != 16 && (q.size() == 0 || a == model_next);
    chk("in_ready", in_ready, exp_rdy);
    acc = stb & exp_rdy;
    pop = rd & (q.size() != 0);
    @(posedge clk);
    #1;
    if (pop) begin
      e = q.pop_front();
      last_data = e.data;
    end
    if (acc) begin
      e.addr = a;
      e.data = {~s, d};
      q.push_back(e);
      model_next = a + 22'd2;
    end
    chk("fifo_data", fifo_data, last_data);
    chk("fifo_count", fifo_count, q.size());
    chk("fifo_empty", fifo_empty, q.size() == 0);
    chk("fifo_full", fifo_full, q.size() == 16);
    if (q.size() != 0) chk("app_address", app_address, q[0].addr);
    in_stb = 0;
    fifo_read = 0;
  endtask
  initial begin
    logic acc;
    logic got;
    vecs[0] = '{1'b0, 22'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b1, 5'd0, 22'h0, 36'h0};
    vecs[1] = '{1'b1, 22'h123400, 32'hDEADBEEF, 4'b1101, 1'b0, 1'b1, 1'b0, 5'd1, 22'h123400, 36'h0};
    vecs[2] = '{1'b0, 22'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1, 5'd0, 22'h123402, 36'h2_DEADBEEF};
    vecs[3] = '{1'b0, 22'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1, 5'd0, 22'h123402, 36'h2_DEADBEEF};
    do_reset();
    chk("rst_empty", fifo_empty, 1'b1);
    chk("rst_full", fifo_full, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_data", fifo_data, 36'h0);
    chk("rst_app", app_address, 22'h0);
    chk("rst_count", fifo_count, 5'd0);
    for (int i = 0; i < 4; i++) begin
      in_stb = vecs[i].stb;
      in_address = vecs[i].addr;
      in_data = vecs[i].data;
      in_sel = vecs[i].sel;
      fifo_read = vecs[i].rd;
      #1;
      chk("vec_ready", in_ready, vecs[i].exp_ready);
      @(posedge clk);
      #1;
      chk("vec_empty", fifo_empty, vecs[i].exp_empty);
      chk("vec_count", fifo_count, vecs[i].exp_count);
      chk("vec_app", app_address, vecs[i].exp_app);
      chk("vec_data", fifo_data, vecs[i].exp_data);
      chk("vec_full", fifo_full, 1'b0);
    end
    in_stb = 0;
    fifo_read = 0;
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1'b1, 22'h000100 + 22'(2 * i), 1'b0, acc);
    chk("full_after_16", fifo_full, 1'b1);
    cyc(1'b1, 22'h000120, 1'b0, acc);
    cyc(1'b1, 22'h000120, 1'b1, acc);
    cyc(1'b1, 22'h000120, 1'b0, acc);
    chk("refill_count", fifo_count, 5'd16);
    for (int i = 0; i < 20 && q.size() != 0; i++) cyc(1'b0, 22'h0, 1'b1, acc);
    chk("drain_empty", fifo_empty, 1'b1);
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b1, 22'h000100 + 22'(2 * i), 1'b0, acc);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      cyc(1'b1, 22'h000200, 1'b1, acc);
      got = acc;
    end
    if (!got) chk("noncontig_timeout", 1'b0, 1'b1);
    chk("noncontig_app", app_address, 22'h000200);
    cyc(1'b0, 22'h0, 1'b1, acc);
    do_reset();
    cyc(1'b1, 22'h3FFFFA, 1'b0, acc);
    cyc(1'b1, 22'h3FFFFC, 1'b0, acc);
    cyc(1'b1, 22'h3FFFFE, 1'b0, acc);
    cyc(1'b1, 22'h000000, 1'b1, acc);
    chk("simul_count", fifo_count, 5'd3);
    cyc(1'b1, 22'h000002, 1'b1, acc);
    for (int i = 0; i < 8 && q.size() != 0; i++) cyc(1'b0, 22'h0, 1'b1, acc);
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 22'h001000 + 22'(2 * i), 1'b0, acc);
    cyc(1'b0, 22'h0, 1'b1, acc);
    rst = 1;
    @(posedge clk);
    #1;
    chk("midrst_empty", fifo_empty, 1'b1);
    chk("midrst_count", fifo_count, 5'd0);
    chk("midrst_data", fifo_data, 36'h0);
    rst = 0;
    q.delete();
    model_next = '0;
    last_data = '0;
    cyc(1'b1, 22'h2AAAA5, 1'b0, acc);
    cyc(1'b0, 22'h0, 1'b1, acc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
